// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RISC-V front end.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: PC register, request FSM,
// one-entry holding register toward decode, branch redirect and squash handling.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt,
    output logic        flush,
    output logic        misalign_err
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic         squash, squash_n;
    logic         err_n;
    logic         capture;
    logic         redirect, misaligned, stop, accept;
    fetch_state_e entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            squash       <= 1'b0;
            misalign_err <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            squash       <= squash_n;
            misalign_err <= err_n;
            if (capture) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        squash_n = squash;
        err_n    = misalign_err;
        capture  = 1'b0;

        // Once halted on a bad target, redirects are ignored until reset.
        redirect   = br_valid && br_taken && !(state == ST_HALTED && misalign_err);
        misaligned = (br_target[1:0] != 2'b00);
        stop       = redirect && misaligned && HALT_ON_MISALIGN;
        accept     = redirect && !stop;
        entry      = halt ? ST_HALTED : ST_REQ;

        if (redirect && misaligned) err_n = 1'b1;
        if (accept) pc_n = br_target;

        if (stop) begin
            state_n  = ST_HALTED;
            squash_n = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: state_n = entry;
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_n = ST_WAIT;
                        if (accept) squash_n = 1'b1;
                    end else if (accept) begin
                        state_n = entry;
                    end
                end
                ST_WAIT: begin
                    // A redirect coinciding with rvalid discards that response
                    // exactly as a pending squash would.
                    if (imem_rvalid) begin
                        if (accept || squash) begin
                            squash_n = 1'b0;
                            state_n  = entry;
                        end else begin
                            capture = 1'b1;
                            pc_n    = pc + INSTR_BYTES;
                            state_n = ST_HOLD;
                        end
                    end else if (accept) begin
                        squash_n = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (accept || if_ready) state_n = entry;
                end
                ST_HALTED: begin
                    if (!accept && !halt && !misalign_err) state_n = ST_REQ;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;
    assign if_valid  = (state == ST_HOLD);
    assign flush     = accept && !rst;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter HALT_ON_MISALIGN, 1, when 1 a misaligned taken target stops fetching.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, equal to the current PC.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  returned instruction valid.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 if_valid  output  1  instruction available to decode.
REQ-011 if_instr  output  32  held instruction word.
REQ-012 if_pc  output  32  address of if_instr.
REQ-013 if_ready  input  1  decode consumes the instruction this cycle.
REQ-014 br_valid  input  1  branch unit resolution valid, one-cycle pulse.
REQ-015 br_taken  input  1  resolved branch is taken.
REQ-016 br_target  input  32  taken-branch target (iaddr+imm).
REQ-017 halt  input  1  level; stop issuing new fetches.
REQ-018 flush  output  1  one-cycle pulse when a taken redirect is accepted.
REQ-019 misalign_err  output  1  sticky; set on a taken target with target[1:0] != 0.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and HALTED.
REQ-021 IDLE SHALL last exactly one cycle after reset release, then go to REQ, or to HALTED if halt=1.
REQ-022 REQ: imem_req=1 and imem_addr=pc; on imem_gnt go to WAIT; else stay in REQ with address stable.
REQ-023 WAIT: on imem_rvalid, capture if_instr=imem_rdata and if_pc=pc, then go to HOLD; pc <= pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
REQ-024 HOLD: if_valid=1; on if_ready go to REQ, or to HALTED if halt=1. Fetch-to-decode latency SHALL be a minimum of 3 cycles (REQ->WAIT->HOLD).
REQ-025 Only one request SHALL be outstanding; imem_rvalid outside WAIT SHALL be ignored.
REQ-026 A taken redirect (br_valid & br_taken) SHALL have priority over every other event in every state except HALTED-by-misalign: pc <= br_target and flush=1 in the same cycle.
REQ-027 Redirect in REQ without gnt: go to REQ next cycle at the target. Redirect in REQ with gnt in the same cycle: set squash and go to WAIT.
REQ-028 Redirect in WAIT: set squash. The next imem_rvalid SHALL be discarded (if_valid stays 0), squash cleared, then go to REQ at the target. A redirect in the same cycle as rvalid is treated identically.
REQ-029 Redirect in HOLD: drop the held instruction (if_valid=0 next cycle) and go to REQ, even if if_ready=1 in that cycle.
REQ-030 Not-taken resolution (br_valid & !br_taken) SHALL have no effect.
REQ-031 Taken target with target[1:0]!=0: set misalign_err and, if HALT_ON_MISALIGN=1, go to HALTED with no flush-driven fetch.
REQ-032 HALTED: imem_req=0, if_valid=0. Leave to REQ when halt=0 and misalign_err=0; a taken redirect while halted SHALL update pc without leaving HALTED.
REQ-033 halt SHALL NOT abort a granted request; it takes effect only at REQ-entry decisions and in HOLD.

Reset
REQ-034 When rst=1: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, flush=0, misalign_err=0, squash=0.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after reset SHALL be ignored.

Structure
REQ-036 The fetch_state_e enum and the RESET_PC default constant SHALL live in riscv_pkg.
REQ-037 No sub-module is required; the FSM, PC register and holding register are one module.

Verification
REQ-038 Reset with RESET_PC=32'h100, gnt and rvalid tied 1 -> addresses 0x100, 0x104, 0x108 delivered; first if_valid on cycle 3 after reset release.
REQ-039 Taken redirect to 0x200 while in WAIT for 0x104 -> flush pulses, the 0x104 data is discarded, next imem_addr=0x200, and if_pc=0x200 is delivered next.
REQ-040 Redirect to 0x300 in HOLD with if_ready=1 in the same cycle -> held instruction is not consumed; next fetch is 0x300.
REQ-041 Taken target 0x302 -> misalign_err=1, state HALTED, imem_req stays 0 until reset.
REQ-042 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0.
REQ-043 halt=1 asserted during WAIT -> response delivered in HOLD, no new request after if_ready; halt=0 -> resumes at pc+4.
